run_sequencer: RTL and testbench

RUN_SEQUENCER -- requirements
Module: run_sequencer

---
 rtl/run_sequencer.sv | 140 ++++++++++++++
 tb/tb_run_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_sequencer.sv
// run_sequencer: launches three core programs, reads back each result table and streams the bytes; SEQ_TIMEOUT_EN adds a RUN watchdog
module run_sequencer #(
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 4096
) (
    input  logic       CLK,
    input  logic       reset_n,
    input  logic       go,
    input  logic       halt,
    output logic       start,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [1:0] res_prog,
    output logic       res_last,
    output logic       busy,
    output logic       done,
    output logic       timeout_err
);
    if (START_CYCLES < 1 || START_CYCLES > 255) begin : g_bad_start
        $error("START_CYCLES out of range 1..255");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("TIMEOUT out of range 1..65535");
    end

    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, READ, EMIT, NEXT, DONE} state_e;

    state_e     state_q, state_d;
    logic [1:0] prog_q, prog_d, idx_q, idx_d;
    logic [7:0] lcnt_q, lcnt_d, res_data_q, res_data_d;
    logic [7:0] tbl_addr;
    logic       last;
`ifdef SEQ_TIMEOUT_EN
    logic [15:0] tcnt_q, tcnt_d;
    logic        terr_q, terr_d;
`endif

    // readback table: p1 {10,11}, p2 {4,5,6}, p3 {14}
    assign tbl_addr = prog_q == 2'd0 ? 8'd10 + {6'd0, idx_q} :
                      prog_q == 2'd1 ? 8'd4 + {6'd0, idx_q} : 8'd14;
    assign last     = prog_q == 2'd0 ? idx_q == 2'd1 :
                      prog_q == 2'd1 ? idx_q == 2'd2 : 1'b1;

    always_comb begin
        state_d    = state_q;
        prog_d     = prog_q;
        idx_d      = idx_q;
        lcnt_d     = lcnt_q;
        res_data_d = res_data_q;
`ifdef SEQ_TIMEOUT_EN
        tcnt_d     = tcnt_q;
        terr_d     = terr_q;
`endif
        case (state_q)
            IDLE, DONE: if (go) begin
                state_d = LAUNCH;
                prog_d  = 2'd0;
                idx_d   = 2'd0;
                lcnt_d  = 8'd0;
`ifdef SEQ_TIMEOUT_EN
                terr_d  = 1'b0;
`endif
            end
            LAUNCH: if (lcnt_q == 8'(START_CYCLES - 1)) begin
                state_d = RUN;
                lcnt_d  = 8'd0;
`ifdef SEQ_TIMEOUT_EN
                tcnt_d  = 16'd0;
`endif
            end else begin
                lcnt_d = lcnt_q + 8'd1;
            end
            RUN: if (halt) begin
                state_d = READ;
`ifdef SEQ_TIMEOUT_EN
            end else if (tcnt_q == 16'(TIMEOUT - 1)) begin
                state_d = DONE;
                terr_d  = 1'b1;
            end else begin
                tcnt_d = tcnt_q + 16'd1;
`endif
            end
            READ: begin
                res_data_d = mem_rdata;
                state_d    = EMIT;
            end
            EMIT: if (res_ready) begin
                state_d = last ? NEXT : READ;
                idx_d   = last ? 2'd0 : idx_q + 2'd1;
            end
            NEXT: begin
                state_d = prog_q == 2'd2 ? DONE : LAUNCH;
                prog_d  = prog_q == 2'd2 ? prog_q : prog_q + 2'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            prog_q     <= 2'd0;
            idx_q      <= 2'd0;
            lcnt_q     <= 8'd0;
            res_data_q <= 8'd0;
`ifdef SEQ_TIMEOUT_EN
            tcnt_q     <= 16'd0;
            terr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            prog_q     <= prog_d;
            idx_q      <= idx_d;
            lcnt_q     <= lcnt_d;
            res_data_q <= res_data_d;
`ifdef SEQ_TIMEOUT_EN
            tcnt_q     <= tcnt_d;
            terr_q     <= terr_d;
`endif
        end
    end

    assign start     = state_q == IDLE || state_q == LAUNCH || state_q == DONE;
    assign busy      = state_q == LAUNCH || state_q == RUN || state_q == READ ||
                       state_q == EMIT || state_q == NEXT;
    assign done      = state_q == DONE;
    assign res_valid = state_q == EMIT;
    assign res_last  = state_q == EMIT && last;
    assign res_prog  = prog_q;
    assign res_data  = res_data_q;
    assign mem_addr  = state_q == READ ? tbl_addr : 8'd0;
`ifdef SEQ_TIMEOUT_EN
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed tests of run_sequencer with a core model that halts a fixed delay after start falls
module tb_run_sequencer;
    logic       CLK = 1'b0;
    logic       reset_n, go, halt, start, res_valid, res_ready, res_last, busy, done, timeout_err;
    logic [7:0] mem_addr, mem_rdata, res_data;
    logic [1:0] res_prog;
    logic [7:0] mem [256];
    logic       halt_pre, block_p1;
    int         halt_delay = 20;
    int         run_cnt = 0;
    int         pass_cnt = 0;
    int         total = 0;
    logic [10:0] xq [$];
    logic [7:0]  aq [$];
    int          lens [$];
    int          launch_len = 0;
    logic [1:0]  ep [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
    logic [7:0]  ea [6] = '{8'd10, 8'd11, 8'd4, 8'd5, 8'd6, 8'd14};
    logic        el [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    always #5 CLK = ~CLK;

    run_sequencer #(.START_CYCLES(2), .TIMEOUT(50)) dut (
        .CLK(CLK), .reset_n(reset_n), .go(go), .halt(halt), .start(start),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_prog(res_prog),
        .res_last(res_last), .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    assign mem_rdata = mem[mem_addr];
    assign halt = halt_pre | (!start && run_cnt >= halt_delay && !(block_p1 && res_prog == 2'd1));
    always @(posedge CLK) run_cnt <= start ? 0 : run_cnt + 1;

    always @(negedge CLK) begin
        if (res_valid && res_ready) xq.push_back({res_prog, res_last, res_data});
        if (mem_addr != 8'd0) aq.push_back(mem_addr);
        if (start && busy) launch_len++;
        else if (launch_len != 0) begin
            lens.push_back(launch_len);
            launch_len = 0;
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_go;
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        total++;
        if (done !== 1'b1) $display("FAIL %s: done=%b never rose, required 1", nm, done);
        else pass_cnt++;
    endtask

    task automatic check_run(input int bx, input int ba, input int bl, input string nm);
        total++;
        if (xq.size() - bx !== 6) $display("FAIL %s byte count: got %0d required 6", nm, xq.size() - bx);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            if (bx + i < xq.size()) begin
                total++;
                if (xq[bx+i] !== {ep[i], el[i], mem[ea[i]]})
                    $display("FAIL %s byte%0d {prog,last,data}: got %h required %h", nm, i, xq[bx+i], {ep[i], el[i], mem[ea[i]]});
                else pass_cnt++;
            end
            if (ba + i < aq.size()) begin
                total++;
                if (aq[ba+i] !== ea[i]) $display("FAIL %s addr%0d: got %0d required %0d", nm, i, aq[ba+i], ea[i]);
                else pass_cnt++;
            end
        end
        if (bx + 5 < xq.size()) begin
            total += 3;
            if (xq[bx] !== {2'd0, 1'b0, 8'hA5}) $display("FAIL %s first byte: got %h required %h", nm, xq[bx], {2'd0, 1'b0, 8'hA5});
            else pass_cnt++;
            if (xq[bx+1] !== {2'd0, 1'b1, 8'h3C}) $display("FAIL %s second byte: got %h required %h", nm, xq[bx+1], {2'd0, 1'b1, 8'h3C});
            else pass_cnt++;
            if (xq[bx+5] !== {2'd2, 1'b1, 8'h07}) $display("FAIL %s final byte: got %h required %h", nm, xq[bx+5], {2'd2, 1'b1, 8'h07});
            else pass_cnt++;
        end
        total++;
        if (lens.size() - bl !== 3) $display("FAIL %s launch count: got %0d required 3", nm, lens.size() - bl);
        else pass_cnt++;
        for (int i = bl; i < lens.size(); i++) begin
            total++;
            if (lens[i] !== 2) $display("FAIL %s start width: got %0d required 2", nm, lens[i]);
            else pass_cnt++;
        end
        total++;
        if ({done, busy, start, timeout_err} !== 4'b1010)
            $display("FAIL %s end {done,busy,start,terr}: got %b required 1010", nm, {done, busy, start, timeout_err});
        else pass_cnt++;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; go = 1'b0; res_ready = 1'b1; halt_pre = 1'b0; block_p1 = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        @(negedge CLK);
        total++;
        if ({start, res_valid, busy, done, timeout_err, mem_addr, res_data, res_prog, res_last} !== {5'b10000, 8'd0, 8'd0, 2'd0, 1'b0})
            $display("FAIL reset outputs: got %b_%h_%h_%h_%b required 10000_00_00_0_0",
                     {start, res_valid, busy, done, timeout_err}, mem_addr, res_data, res_prog, res_last);
        else pass_cnt++;
    endtask

    task automatic test_full_run;
        int bx = xq.size(), ba = aq.size(), bl = lens.size();
        tick();
        pulse_go();
        wait_done("full_run");
        check_run(bx, ba, bl, "full_run");
    endtask

    task automatic test_backpressure;
        int bx = xq.size(), ba = aq.size(), bl = lens.size(), n = 0;
        tick();
        res_ready = 1'b0;
        pulse_go();
        while (res_valid !== 1'b1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({res_valid, res_prog, res_last, res_data} !== {1'b1, 2'd0, 1'b0, 8'hA5})
                $display("FAIL stall cycle%0d {valid,prog,last,data}: got %h required %h", k, {res_valid, res_prog, res_last, res_data}, {1'b1, 2'd0, 1'b0, 8'hA5});
            else pass_cnt++;
            if (k < 4) @(negedge CLK);
        end
        total++;
        if (xq.size() !== bx) $display("FAIL stall transfers: got %0d required 0", xq.size() - bx);
        else pass_cnt++;
        tick();
        res_ready = 1'b1;
        wait_done("backpressure");
        check_run(bx, ba, bl, "backpressure");
    endtask

    task automatic test_reset_mid_emit;
        int bx = xq.size(), ba, bl, n = 0;
        tick();
        pulse_go();
        while (xq.size() < bx + 2 && n < 500) begin
            @(negedge CLK);
            n++;
        end
        tick();
        res_ready = 1'b0;
        n = 0;
        while (res_valid !== 1'b1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        total++;
        if ({res_valid, res_prog, res_data} !== {1'b1, 2'd1, mem[4]})
            $display("FAIL third emit {valid,prog,data}: got %h required %h", {res_valid, res_prog, res_data}, {1'b1, 2'd1, mem[4]});
        else pass_cnt++;
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        @(negedge CLK);
        total++;
        if ({start, res_valid, busy, done, mem_addr, res_data, res_prog, res_last} !== {4'b1000, 8'd0, 8'd0, 2'd0, 1'b0})
            $display("FAIL mid-emit reset: got %b_%h_%h_%h_%b required 1000_00_00_0_0",
                     {start, res_valid, busy, done}, mem_addr, res_data, res_prog, res_last);
        else pass_cnt++;
        total++;
        if (xq.size() !== bx + 2) $display("FAIL mid-emit bytes: got %0d required 2", xq.size() - bx);
        else pass_cnt++;
        res_ready = 1'b1;
        bx = xq.size(); ba = aq.size(); bl = lens.size();
        tick();
        pulse_go();
        wait_done("after_reset");
        check_run(bx, ba, bl, "after_reset");
    endtask

    task automatic test_go_ignored;
        int bx = xq.size(), ba = aq.size(), bl = lens.size(), n = 0;
        tick();
        pulse_go();
        while (!(busy === 1'b1 && start === 1'b0) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        tick();
        pulse_go();
        @(negedge CLK);
        total++;
        if ({busy, start} !== 2'b10) $display("FAIL go in RUN {busy,start}: got %b required 10", {busy, start});
        else pass_cnt++;
        wait_done("go_ignored");
        check_run(bx, ba, bl, "go_ignored");
    endtask

    task automatic test_halt_prehigh;
        int bx = xq.size(), ba = aq.size(), bl = lens.size(), n = 0;
        tick();
        halt_pre = 1'b1;
        pulse_go();
        while (!(busy === 1'b1 && start === 1'b0) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        total++;
        if (mem_addr !== 8'd0) $display("FAIL prehigh RUN addr: got %0d required 0", mem_addr);
        else pass_cnt++;
        @(negedge CLK);
        total++;
        if (mem_addr !== 8'd10) $display("FAIL prehigh READ addr: got %0d required 10", mem_addr);
        else pass_cnt++;
        wait_done("prehigh");
        halt_pre = 1'b0;
        check_run(bx, ba, bl, "prehigh");
    endtask

`ifdef SEQ_TIMEOUT_EN
    task automatic test_timeout;
        int bx = xq.size(), n = 0, runs = 0;
        tick();
        block_p1 = 1'b1;
        pulse_go();
        while (!(res_prog === 2'd1 && busy === 1'b1 && start === 1'b0) && n < 500) begin
            @(negedge CLK);
            n++;
        end
        while (busy === 1'b1 && start === 1'b0 && runs < 200) begin
            runs++;
            @(negedge CLK);
        end
        total++;
        if (runs !== 50) $display("FAIL timeout RUN cycles: got %0d required 50", runs);
        else pass_cnt++;
        total++;
        if ({done, timeout_err, start, busy} !== 4'b1110)
            $display("FAIL timeout {done,terr,start,busy}: got %b required 1110", {done, timeout_err, start, busy});
        else pass_cnt++;
        total++;
        if (xq.size() - bx !== 2) $display("FAIL timeout bytes: got %0d required 2", xq.size() - bx);
        else pass_cnt++;
        block_p1 = 1'b0;
        tick();
        pulse_go();
        wait_done("post_timeout");
        total++;
        if (timeout_err !== 1'b0) $display("FAIL timeout_err after rerun: got %b required 0", timeout_err);
        else pass_cnt++;
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        mem[10] = 8'hA5;
        mem[11] = 8'h3C;
        mem[14] = 8'h07;
        test_reset();
        test_full_run();
        test_backpressure();
        test_reset_mid_emit();
        test_go_ignored();
        test_halt_prehigh();
`ifdef SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
